// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals shared between the two RAM clients and ram_port_arbiter.
// Port 0 is the processor FSM and port 1 is the switch/HEX monitor.
`ifndef WORD_LENGTH
`define WORD_LENGTH 16
`endif
`ifndef ARG_LENGTH
`define ARG_LENGTH 8
`endif

interface ram_port_arbiter_if #(
  parameter int WORD_W = `WORD_LENGTH,
  parameter int ADDR_W = `ARG_LENGTH
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [WORD_W-1:0] wdata0;
  logic              ack0;
  logic [WORD_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [WORD_W-1:0] wdata1;
  logic              ack1;
  logic [WORD_W-1:0] rdata1;

  logic [ADDR_W-1:0] ram_read_addr;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [WORD_W-1:0] ram_data;
  logic [WORD_W-1:0] ram_q;
  logic              ram_read_clock;
  logic              ram_write_clock;
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  ack0, rdata0, ack1, rdata1, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_q,
    output ack0, rdata0, ack1, rdata1,
    output ram_read_addr, ram_write_addr, ram_data,
    output ram_read_clock, ram_write_clock, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter sequencing strobe-pulse accesses to a dual-clock RAM.
// Define ARB_CPU_PRIORITY_EN for fixed priority (port 0 always wins a tie).
`ifndef WORD_LENGTH
`define WORD_LENGTH 16
`endif
`ifndef ARG_LENGTH
`define ARG_LENGTH 8
`endif

module ram_port_arbiter #(
  parameter int WORD_W = `WORD_LENGTH,
  parameter int ADDR_W = `ARG_LENGTH
) (
  input logic               clock,
  input logic               reset,
  ram_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] STROBE_LOW  = 2'd1;
  localparam logic [1:0] STROBE_HIGH = 2'd2;
  localparam logic [1:0] ACK         = 2'd3;

  logic [1:0]        state;
  logic              last_grant;
  logic              sel;
  logic              sel_we;

  logic              any_req;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [WORD_W-1:0] win_wdata;

  always_comb begin
    any_req = bus.req0 | bus.req1;
`ifdef ARB_CPU_PRIORITY_EN
    win = ~bus.req0;
`else
    // On a tie the port that did not win last time goes; otherwise the lone requester.
    win = (bus.req0 && bus.req1) ? ~last_grant : ~bus.req0;
`endif
    win_we    = win ? bus.we1    : bus.we0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  // Strobe drops at the edge leaving STROBE_LOW, so an abort there never produces a RAM edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      last_grant          <= 1'b1;
      sel                 <= 1'b0;
      sel_we              <= 1'b0;
      bus.ack0            <= 1'b0;
      bus.ack1            <= 1'b0;
      bus.rdata0          <= '0;
      bus.rdata1          <= '0;
      bus.ram_read_addr   <= '0;
      bus.ram_write_addr  <= '0;
      bus.ram_data        <= '0;
      bus.ram_read_clock  <= 1'b1;
      bus.ram_write_clock <= 1'b1;
      bus.busy            <= 1'b0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel        <= win;
            last_grant <= win;
            sel_we     <= win_we;
            if (win_we) begin
              bus.ram_write_addr <= win_addr;
              bus.ram_data       <= win_wdata;
            end else begin
              bus.ram_read_addr  <= win_addr;
            end
            state    <= STROBE_LOW;
            bus.busy <= 1'b1;
          end
        end
        STROBE_LOW: begin
          if (sel_we) bus.ram_write_clock <= 1'b0;
          else        bus.ram_read_clock  <= 1'b0;
          state <= STROBE_HIGH;
        end
        STROBE_HIGH: begin
          bus.ram_read_clock  <= 1'b1;
          bus.ram_write_clock <= 1'b1;
          state               <= ACK;
        end
        default: begin
          if (sel) begin
            bus.ack1 <= 1'b1;
            if (!sel_we) bus.rdata1 <= bus.ram_q;
          end else begin
            bus.ack0 <= 1'b1;
            if (!sel_we) bus.rdata0 <= bus.ram_q;
          end
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
